// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan receiver: rebuilds the four displayed hex digits
// from the multiplexed anode/cathode lines once each dwell has settled.
module ssd_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  An,
    input  logic [7:0]  Cath,
    output logic [15:0] Digits,
    output logic [3:0]  Digit_valid,
    output logic [3:0]  Dp_out,
    output logic        Frame_valid,
    output logic        Err,
    output logic [1:0]  Err_code,
    output logic        Stale
);
    localparam logic [7:0]  SETTLE  = 8'(SETTLE_CYCLES);
    localparam logic [20:0] TIMEOUT = 21'(TIMEOUT_CYCLES);

    logic [3:0]  r_an_q, r_an_d;
    logic [7:0]  r_cath_q, r_cath_d;
    logic [11:0] prev_q, prev_d;
    logic [7:0]  stab_q, stab_d;
    logic        hit_q, hit_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  dp_q, dp_d;
    logic        frame_q, frame_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        stale_q, stale_d;
    logic [3:0]  seen_q, seen_d;
    logic [20:0] idle_q, idle_d;

    logic        stable;
    logic        qual;
    logic        capture;
    logic [3:0]  low;
    logic        multi;
    logic [1:0]  idx;
    logic [4:0]  dec;
    logic [3:0]  seen_nx;

    // Returns {match, value}; match is 0 for anything outside the hex table.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0;
        case (seg)
            7'b0000001: res = {1'b1, 4'h0};
            7'b1001111: res = {1'b1, 4'h1};
            7'b0010010: res = {1'b1, 4'h2};
            7'b0000110: res = {1'b1, 4'h3};
            7'b1001100: res = {1'b1, 4'h4};
            7'b0100100: res = {1'b1, 4'h5};
            7'b0100000: res = {1'b1, 4'h6};
            7'b0001111: res = {1'b1, 4'h7};
            7'b0000000: res = {1'b1, 4'h8};
            7'b0000100: res = {1'b1, 4'h9};
            7'b0001000: res = {1'b1, 4'hA};
            7'b1100000: res = {1'b1, 4'hB};
            7'b0110001: res = {1'b1, 4'hC};
            7'b1000010: res = {1'b1, 4'hD};
            7'b0110000: res = {1'b1, 4'hE};
            7'b0111000: res = {1'b1, 4'hF};
            default:    res = 5'b0;
        endcase
        return res;
    endfunction

    always_comb begin
        r_an_d     = An;
        r_cath_d   = Cath;
        prev_d     = {r_an_q, r_cath_q};
        digits_d   = digits_q;
        valid_d    = valid_q;
        dp_d       = dp_q;
        frame_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        stale_d    = stale_q;
        seen_d     = seen_q;
        idle_d     = idle_q;
        capture    = 1'b0;
        seen_nx    = seen_q;
        idx        = 2'd0;

        stable = ({r_an_q, r_cath_q} == prev_q);
        if (!stable)
            stab_d = 8'd1;
        else if (stab_q == SETTLE)
            stab_d = stab_q;
        else
            stab_d = stab_q + 8'd1;
        hit_d = (stab_q == SETTLE);
        qual  = (stab_q == SETTLE) && !hit_q;

        // prev_q holds the pattern that was actually stable for the window,
        // even if the pins moved again on the qualifying edge.
        low   = ~prev_q[11:8];
        multi = |(low & (low - 4'd1));
        for (int i = 3; i >= 0; i--) begin
            if (low[i])
                idx = 2'(i);
        end
        dec = seg_decode(prev_q[7:1]);

        if (qual && (|low)) begin
            if (multi) begin
                err_d      = 1'b1;
                err_code_d = 2'b10;
            end else begin
                capture = 1'b1;
                if (dec[4]) begin
                    digits_d[{idx, 2'b00} +: 4] = dec[3:0];
                    valid_d[idx] = 1'b1;
                    dp_d[idx]    = ~prev_q[0];
                end else if (prev_q[7:1] == 7'h7F) begin
                    digits_d[{idx, 2'b00} +: 4] = 4'h0;
                    valid_d[idx] = 1'b0;
                    dp_d[idx]    = ~prev_q[0];
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                end
                seen_nx = seen_q | (4'b0001 << idx);
                if (seen_nx == 4'hF) begin
                    frame_d = 1'b1;
                    seen_d  = 4'h0;
                end else begin
                    seen_d = seen_nx;
                end
            end
        end

        if (capture) begin
            idle_d  = 21'd0;
            stale_d = 1'b0;
        end else begin
            idle_d = (idle_q == TIMEOUT) ? idle_q : idle_q + 21'd1;
            if (idle_d == TIMEOUT) begin
                stale_d = 1'b1;
                valid_d = 4'h0;
                seen_d  = 4'h0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_an_q     <= 4'hF;
            r_cath_q   <= 8'hFF;
            prev_q     <= 12'hFFF;
            stab_q     <= 8'd0;
            hit_q      <= 1'b0;
            digits_q   <= 16'h0;
            valid_q    <= 4'h0;
            dp_q       <= 4'h0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            stale_q    <= 1'b1;
            seen_q     <= 4'h0;
            idle_q     <= 21'd0;
        end else begin
            r_an_q     <= r_an_d;
            r_cath_q   <= r_cath_d;
            prev_q     <= prev_d;
            stab_q     <= stab_d;
            hit_q      <= hit_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            stale_q    <= stale_d;
            seen_q     <= seen_d;
            idle_q     <= idle_d;
        end
    end

    assign Digits      = digits_q;
    assign Digit_valid = valid_q;
    assign Dp_out      = dp_q;
    assign Frame_valid = frame_q;
    assign Err         = err_q;
    assign Err_code    = err_code_q;
    assign Stale       = stale_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder with a short settle window and
// a short timeout so every boundary is reachable in a few hundred cycles.
module tb_ssd_scan_decoder;
    logic        Clk;
    logic        Reset;
    logic [3:0]  An;
    logic [7:0]  Cath;
    logic [15:0] Digits;
    logic [3:0]  Digit_valid;
    logic [3:0]  Dp_out;
    logic        Frame_valid;
    logic        Err;
    logic [1:0]  Err_code;
    logic        Stale;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int fv_cnt   = 0;
    int fv_at    = 0;

    ssd_scan_decoder #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .An         (An),
        .Cath       (Cath),
        .Digits     (Digits),
        .Digit_valid(Digit_valid),
        .Dp_out     (Dp_out),
        .Frame_valid(Frame_valid),
        .Err        (Err),
        .Err_code   (Err_code),
        .Stale      (Stale)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        err_cnt = 0;
        fv_cnt  = 0;
        fv_at   = 0;
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] cath,
                        input int n);
        An   = an;
        Cath = cath;
        for (int i = 0; i < n; i++) begin
            tick();
            if (Err) err_cnt++;
            if (Frame_valid) begin
                fv_cnt++;
                fv_at = i + 1;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_digits"}, Digits, 16'h0);
        check({tag, "_valid"}, Digit_valid, 4'h0);
        check({tag, "_dp"}, Dp_out, 4'h0);
        check({tag, "_frame"}, Frame_valid, 1'b0);
        check({tag, "_err"}, Err, 1'b0);
        check({tag, "_code"}, Err_code, 2'b00);
        check({tag, "_stale"}, Stale, 1'b1);
    endtask

    initial begin
        Reset = 1'b1;
        An    = 4'hF;
        Cath  = 8'hFF;
        tick();
        tick();
        check_reset("rst");
        Reset = 1'b0;
        hold(4'hF, 8'hFF, 3);

        // single digit 3, latency e0+SETTLE+1
        clr();
        hold(4'b1110, 8'b00001101, 5);
        check("t1_pre_valid", Digit_valid, 4'b0000);
        hold(4'b1110, 8'b00001101, 1);
        check("t1_nib0", Digits[3:0], 4'h3);
        check("t1_valid", Digit_valid, 4'b0001);
        check("t1_stale", Stale, 1'b0);
        check("t1_dp", Dp_out, 4'b0000);
        hold(4'b1110, 8'b00001101, 4);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_nib0_hold", Digits[3:0], 4'h3);

        // full scan: 5, A(dp), blank, F
        clr();
        hold(4'b1110, 8'b01001001, 20);
        hold(4'b1101, 8'b00010000, 20);
        hold(4'b1011, 8'hFF, 20);
        hold(4'b0111, 8'b01110001, 6);
        check("t2_fv_at", fv_at, 6);
        hold(4'b0111, 8'b01110001, 14);
        check("t2_digits", Digits, 16'hF0A5);
        check("t2_valid", Digit_valid, 4'b1011);
        check("t2_dp", Dp_out, 4'b0010);
        check("t2_fv_cnt", fv_cnt, 1);
        check("t2_err_cnt", err_cnt, 0);

        // glitch on digit 0
        hold(4'b1110, 8'b10011111, 10);
        check("t3_nib0_a", Digits[3:0], 4'h1);
        hold(4'b1110, 8'b00011111, 2);
        hold(4'b1110, 8'b10011111, 4);
        check("t3_nib0_b", Digits[3:0], 4'h1);
        hold(4'b1110, 8'b10011111, 10);
        check("t3_nib0_c", Digits[3:0], 4'h1);

        // illegal pattern and multiple anodes
        clr();
        hold(4'b1011, 8'b10011001, 10);
        check("t4_nib2", Digits[11:8], 4'h4);
        clr();
        hold(4'b1011, 8'b11111101, 10);
        check("t4_ill_err", err_cnt, 1);
        check("t4_ill_code", Err_code, 2'b01);
        check("t4_ill_nib2", Digits[11:8], 4'h4);
        check("t4_ill_valid", Digit_valid, 4'b1111);
        clr();
        hold(4'b1100, 8'b00000011, 10);
        check("t4_multi_err", err_cnt, 1);
        check("t4_multi_code", Err_code, 2'b10);
        check("t4_multi_digits", Digits, 16'hF4A1);

        // frame then timeout
        clr();
        hold(4'b1110, 8'b00000001, 20);
        hold(4'b1101, 8'b00001001, 20);
        hold(4'b1011, 8'b01100011, 20);
        hold(4'b0111, 8'b10000101, 6);
        check("t5_fv_cnt", fv_cnt, 1);
        check("t5_fv_at", fv_at, 6);
        check("t5_digits", Digits, 16'hDC98);
        check("t5_valid", Digit_valid, 4'b1111);
        hold(4'hF, 8'hFF, 63);
        check("t5_stale_pre", Stale, 1'b0);
        hold(4'hF, 8'hFF, 1);
        check("t5_stale", Stale, 1'b1);
        check("t5_to_valid", Digit_valid, 4'b0000);
        check("t5_to_digits", Digits, 16'hDC98);
        check("t5_to_dp", Dp_out, 4'b0000);
        hold(4'b1110, 8'b00000001, 6);
        check("t5_recap_stale", Stale, 1'b0);
        check("t5_recap_valid", Digit_valid, 4'b0001);

        // reset mid-dwell
        hold(4'b1101, 8'b00100101, 3);
        Reset = 1'b1;
        tick();
        check_reset("mrst");
        Reset = 1'b0;
        hold(4'b1101, 8'b00100101, 5);
        check("t6_pre_valid", Digit_valid, 4'b0000);
        hold(4'b1101, 8'b00100101, 1);
        check("t6_valid", Digit_valid, 4'b0010);
        check("t6_nib1", Digits[7:4], 4'h2);
        check("t6_stale", Stale, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
